// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// ALU operation codes, PC source selects and the decoded control word.
package multi_cycle_control_unit_pkg;

    localparam int OPW = 6;
    localparam int STW = 3;

    typedef enum logic [STW-1:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EXE  = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_HALT = 3'b111
    } stateT;

    localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OPW-1:0] OP_AND   = 6'b010000;
    localparam logic [OPW-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPW-1:0] OP_SLT   = 6'b011000;
    localparam logic [OPW-1:0] OP_SLTI  = 6'b011001;
    localparam logic [OPW-1:0] OP_SLL   = 6'b011100;
    localparam logic [OPW-1:0] OP_SW    = 6'b110000;
    localparam logic [OPW-1:0] OP_LW    = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b110101;
    localparam logic [OPW-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OPW-1:0] OP_J     = 6'b111000;
    localparam logic [OPW-1:0] OP_JR    = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
    localparam logic [OPW-1:0] OP_HALT  = 6'b111111;
    // Unassigned code used as the reset value of the opcode latch
    localparam logic [OPW-1:0] OP_NOP   = 6'b100000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JR     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] DST_RA = 2'b00;
    localparam logic [1:0] DST_RT = 2'b01;
    localparam logic [1:0] DST_RD = 2'b10;

    typedef struct packed {
        logic       pcWre;
        logic       irWre;
        logic       insMemRW;
        logic       regWre;
        logic [1:0] regDst;
        logic       wrRegDSrc;
        logic       dbDataSrc;
        logic       aluSrcA;
        logic       aluSrcB;
        logic       extSel;
        logic [2:0] aluOp;
        logic       mRD;
        logic       mWR;
        logic [1:0] pcSrc;
    } ctrlWordT;

    function automatic logic isKnownOp(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLT, OP_SLTI,
            OP_SLL, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ, OP_J, OP_JR,
            OP_JAL, OP_HALT: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    // Instructions whose whole job is done in ID (jumps and anything unrecognised)
    function automatic logic endsInId(input logic [OPW-1:0] op);
        return (op == OP_J) || (op == OP_JR) || (op == OP_JAL) || !isKnownOp(op);
    endfunction

    function automatic logic isBranch(input logic [OPW-1:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
    endfunction

    function automatic logic usesImm(input logic [OPW-1:0] op);
        return (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_SLTI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    // Branch offsets are sign-extended too, since the target adder uses the extender output
    function automatic logic signExtends(input logic [OPW-1:0] op);
        return (op == OP_ADDIU) || (op == OP_SLTI) || (op == OP_LW) ||
               (op == OP_SW) || isBranch(op);
    endfunction

    // Branches compare through a subtract; bltz relies on rt being $0
    function automatic logic [2:0] aluOpFor(input logic [OPW-1:0] op);
        case (op)
            OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: return ALU_SUB;
            OP_AND, OP_ANDI:                 return ALU_AND;
            OP_ORI:                          return ALU_OR;
            OP_SLT, OP_SLTI:                 return ALU_SLT;
            OP_SLL:                          return ALU_SLL;
            default:                         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_control_unit_decode.sv
// Combinational control-word decoder: FSM state, opcode and ALU flags in,
// every datapath enable and mux select out. ID decodes the live opcode
// because the latch only captures it at the end of that cycle.
module ControlDecode
    import multi_cycle_control_unit_pkg::*;
(
    input  stateT          state,
    input  logic [OPW-1:0] liveOp,
    input  logic [OPW-1:0] latchedOp,
    input  logic           zero,
    input  logic           sign,
    output ctrlWordT       ctrl
);

    logic [OPW-1:0] op;
    logic           branchTaken;

    // Build the control word for the current state, all fields zero unless used
    always_comb begin
        ctrl        = '0;
        op          = (state == ST_ID) ? liveOp : latchedOp;
        branchTaken = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero) ||
                      ((op == OP_BLTZ) && sign);
        case (state)
            ST_IF: begin
                ctrl.irWre    = 1'b1;
                ctrl.insMemRW = 1'b1;
            end
            ST_ID: begin
                if (endsInId(op)) begin
                    ctrl.pcWre = 1'b1;
                end
                if ((op == OP_J) || (op == OP_JAL)) begin
                    ctrl.pcSrc = PC_JUMP;
                end
                if (op == OP_JR) begin
                    ctrl.pcSrc = PC_JR;
                end
                if (op == OP_JAL) begin
                    ctrl.regWre    = 1'b1;
                    ctrl.regDst    = DST_RA;
                    ctrl.wrRegDSrc = 1'b0;
                end
            end
            ST_EXE: begin
                ctrl.aluOp   = aluOpFor(op);
                ctrl.aluSrcA = (op == OP_SLL);
                ctrl.aluSrcB = usesImm(op);
                ctrl.extSel  = signExtends(op);
                if (isBranch(op)) begin
                    ctrl.pcWre = 1'b1;
                    ctrl.pcSrc = branchTaken ? PC_BRANCH : PC_SEQ;
                end
            end
            ST_MEM: begin
                if (op == OP_SW) begin
                    ctrl.mWR   = 1'b1;
                    ctrl.pcWre = 1'b1;
                end
                if (op == OP_LW) begin
                    ctrl.mRD = 1'b1;
                end
            end
            ST_WB: begin
                ctrl.pcWre     = 1'b1;
                ctrl.regWre    = 1'b1;
                ctrl.wrRegDSrc = 1'b1;
                ctrl.regDst    = usesImm(op) ? DST_RT : DST_RD;
                if (op == OP_LW) begin
                    ctrl.mRD       = 1'b1;
                    ctrl.dbDataSrc = 1'b1;
                end
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU control unit: state register, opcode latch and next-state
// logic, with the control word produced by ControlDecode. Write/read enables
// are masked while reset is held so an aborted instruction touches nothing.
module multi_cycle_control_unit
    import multi_cycle_control_unit_pkg::*;
(
    input  logic           CLK,
    input  logic           Reset,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           sign,
    output logic           PCWre,
    output logic           IRWre,
    output logic           InsMemRW,
    output logic           RegWre,
    output logic [1:0]     RegDst,
    output logic           WrRegDSrc,
    output logic           DBDataSrc,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic           ExtSel,
    output logic [2:0]     ALUOp,
    output logic           mRD,
    output logic           mWR,
    output logic [1:0]     PCSrc,
    output logic [STW-1:0] state
);

    stateT          currentState;
    logic [OPW-1:0] latchedOp;
    ctrlWordT       ctrl;

    // Advance the instruction FSM and capture the opcode during ID
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            currentState <= ST_IF;
            latchedOp    <= OP_NOP;
        end else begin
            case (currentState)
                ST_IF: begin
                    currentState <= ST_ID;
                end
                ST_ID: begin
                    latchedOp <= opcode;
                    if (opcode == OP_HALT) begin
                        currentState <= ST_HALT;
                    end else if (endsInId(opcode)) begin
                        currentState <= ST_IF;
                    end else begin
                        currentState <= ST_EXE;
                    end
                end
                ST_EXE: begin
                    if (isBranch(latchedOp)) begin
                        currentState <= ST_IF;
                    end else if ((latchedOp == OP_LW) || (latchedOp == OP_SW)) begin
                        currentState <= ST_MEM;
                    end else begin
                        currentState <= ST_WB;
                    end
                end
                ST_MEM: begin
                    currentState <= (latchedOp == OP_LW) ? ST_WB : ST_IF;
                end
                ST_WB: begin
                    currentState <= ST_IF;
                end
                ST_HALT: begin
                    currentState <= ST_HALT;
                end
                default: begin
                    currentState <= ST_IF;
                end
            endcase
        end
    end

    ControlDecode decode (
        .state     (currentState),
        .liveOp    (opcode),
        .latchedOp (latchedOp),
        .zero      (zero),
        .sign      (sign),
        .ctrl      (ctrl)
    );

    assign PCWre     = ctrl.pcWre    & Reset;
    assign IRWre     = ctrl.irWre    & Reset;
    assign InsMemRW  = ctrl.insMemRW & Reset;
    assign RegWre    = ctrl.regWre   & Reset;
    assign mRD       = ctrl.mRD      & Reset;
    assign mWR       = ctrl.mWR      & Reset;
    assign RegDst    = ctrl.regDst;
    assign WrRegDSrc = ctrl.wrRegDSrc;
    assign DBDataSrc = ctrl.dbDataSrc;
    assign ALUSrcA   = ctrl.aluSrcA;
    assign ALUSrcB   = ctrl.aluSrcB;
    assign ExtSel    = ctrl.extSel;
    assign ALUOp     = ctrl.aluOp;
    assign PCSrc     = ctrl.pcSrc;
    assign state     = currentState;

endmodule
